// File: rtl/pip_fetch_queue.sv
// Elastic fetch/decode queue of {instruction, PC} pairs. The head is registered, so decode sees the
// same one-cycle latency as a plain pipeline register. Flush and Reset present a zero bubble.
module pip_fetch_queue #(
    parameter int unsigned INST_W   = 32,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       Flush,
    input  logic                       StallD,
    input  logic                       in_valid,
    input  logic [INST_W-1:0]          Inst_in,
    input  logic [PC_W-1:0]            PC_in,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [INST_W-1:0]          Inst_out,
    output logic [PC_W-1:0]            PC_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic pop;
    logic push;
    logic clear;

    assign clear     = Reset | Flush;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & ~StallD;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign in_ready  = (count_q < CNT_W'(DEPTH)) | pop;
    assign push      = in_valid & in_ready;

    assign count       = count_q;
    assign almost_full = (count_q >= CNT_W'(AF_LEVEL));

    // Gate the head so stale storage never reaches decode.
    always_comb begin
        Inst_out = '0;
        PC_out   = '0;
        if (out_valid) begin
            Inst_out = inst_mem[rd_ptr_q];
            PC_out   = pc_mem[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            inst_mem[wr_ptr_q] <= Inst_in;
            pc_mem[wr_ptr_q]   <= PC_in;
        end
    end

endmodule

// File: tb/tb_pip_fetch_queue.sv
// Directed and randomised checks of pip_fetch_queue against hand-computed values and a queue model.
module tb_pip_fetch_queue;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              Reset, Flush, StallD, in_valid;
    logic [INST_W-1:0] Inst_in;
    logic [PC_W-1:0]   PC_in;
    logic              in_ready, out_valid, almost_full;
    logic [INST_W-1:0] Inst_out;
    logic [PC_W-1:0]   PC_out;
    logic [CNT_W-1:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    pip_fetch_queue #(
        .INST_W  (INST_W),
        .PC_W    (PC_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(DEPTH - 1)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Flush      (Flush),
        .StallD     (StallD),
        .in_valid   (in_valid),
        .Inst_in    (Inst_in),
        .PC_in      (PC_in),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .Inst_out   (Inst_out),
        .PC_out     (PC_out),
        .count      (count),
        .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid = v;
        Inst_in  = inst;
        PC_in    = pc;
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".inst"}, Inst_out, 32'd0);
        check({tag, ".pc"}, PC_out, 32'd0);
        check({tag, ".count"}, 32'(count), 32'd0);
    endtask

    logic [31:0] heads [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    logic [31:0] model_inst [$];
    logic [31:0] model_pc [$];

    initial begin
        Reset = 1'b1;
        Flush = 1'b0;
        StallD = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        tick();
        tick();
        Reset = 1'b0;
        #1;
        check_empty("reset");
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.af", 32'(almost_full), 32'd0);

        // Test 1: single entry, one-cycle latency, then drained.
        drive(1'b1, 32'h20080005, 32'h00400000);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        #1;
        check("t1.out_valid", 32'(out_valid), 32'd1);
        check("t1.inst", Inst_out, 32'h20080005);
        check("t1.pc", PC_out, 32'h00400000);
        check("t1.count", 32'(count), 32'd1);
        tick();
        #1;
        check_empty("t1.drain");

        // Test 2: fill while stalled; fifth push is refused.
        StallD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h11 * (i + 1), 32'h1000 + 4 * i);
            #1;
            check("t2.in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
            #1;
            check("t2.count", 32'(count), (i < 4) ? i + 1 : 4);
            check("t2.af", 32'(almost_full), (i >= 2) ? 32'd1 : 32'd0);
            check("t2.inst", Inst_out, 32'h11);
            check("t2.pc", PC_out, 32'h1000);
        end

        // Test 3: full with simultaneous push and pop; pointers wrap.
        StallD = 1'b0;
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 32'h55 + 32'h11 * j, 32'h2000 + 4 * j);
            #1;
            check("t3.head", Inst_out, heads[j]);
            check("t3.in_ready", 32'(in_ready), 32'd1);
            tick();
            #1;
            check("t3.count", 32'(count), 32'd4);
        end
        drive(1'b0, 32'd0, 32'd0);
        for (int j = 0; j < 4; j++) begin
            #1;
            check("t3.drain_inst", Inst_out, 32'h77 + 32'h11 * j);
            check("t3.drain_pc", PC_out, 32'h2008 + 4 * j);
            tick();
        end
        #1;
        check_empty("t3.empty");

        // Test 4: Flush with a simultaneous push while stalled.
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA1 + i, 32'h3000 + 4 * i);
            tick();
        end
        #1;
        check("t4.count", 32'(count), 32'd3);
        Flush = 1'b1;
        drive(1'b1, 32'hBAD, 32'hBAD0);
        tick();
        Flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        #1;
        check_empty("t4.flush");
        tick();
        #1;
        check_empty("t4.after");

        // Test 5: Reset mid-stream with StallD toggling.
        StallD = 1'b0;
        drive(1'b1, 32'hB1, 32'h4000);
        tick();
        StallD = 1'b1;
        drive(1'b1, 32'hB2, 32'h4004);
        tick();
        StallD = 1'b0;
        drive(1'b1, 32'hB3, 32'h4008);
        tick();
        #1;
        check("t5.count", 32'(count), 32'd2);
        check("t5.head", Inst_out, 32'hB2);
        Reset = 1'b1;
        StallD = 1'b1;
        drive(1'b1, 32'hB4, 32'h400C);
        tick();
        Reset = 1'b0;
        StallD = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        #1;
        check_empty("t5.reset");
        check("t5.in_ready", 32'(in_ready), 32'd1);
        check("t5.af", 32'(almost_full), 32'd0);
        drive(1'b1, 32'hC1, 32'h5000);
        tick();
        StallD = 1'b1;
        drive(1'b1, 32'hC2, 32'h5004);
        #1;
        check("t5.c1_inst", Inst_out, 32'hC1);
        check("t5.c1_pc", PC_out, 32'h5000);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        #1;
        check("t5.hold", Inst_out, 32'hC1);
        check("t5.count2", 32'(count), 32'd2);
        StallD = 1'b0;
        tick();
        #1;
        check("t5.c2_inst", Inst_out, 32'hC2);
        check("t5.c2_pc", PC_out, 32'h5004);

        // Test 6: random traffic against a queue model.
        Reset = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            logic        v, st, fl, exp_valid, exp_pop, exp_ready;
            logic [31:0] exp_inst, exp_pc;
            v  = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 63) == 0);
            StallD = st;
            Flush  = fl;
            drive(v, $urandom, $urandom);
            #1;
            exp_valid = (model_inst.size() != 0);
            exp_inst  = exp_valid ? model_inst[0] : 32'd0;
            exp_pc    = exp_valid ? model_pc[0] : 32'd0;
            exp_pop   = exp_valid & ~st;
            exp_ready = (model_inst.size() < DEPTH) | exp_pop;
            check("t6.out_valid", 32'(out_valid), 32'(exp_valid));
            check("t6.inst", Inst_out, exp_inst);
            check("t6.pc", PC_out, exp_pc);
            check("t6.count", 32'(count), model_inst.size());
            check("t6.in_ready", 32'(in_ready), 32'(exp_ready));
            check("t6.af", 32'(almost_full), (model_inst.size() >= DEPTH - 1) ? 32'd1 : 32'd0);
            if (fl) begin
                model_inst.delete();
                model_pc.delete();
            end else begin
                if (exp_pop) begin
                    void'(model_inst.pop_front());
                    void'(model_pc.pop_front());
                end
                if (v && exp_ready) begin
                    model_inst.push_back(Inst_in);
                    model_pc.push_back(PC_in);
                end
            end
            tick();
        end
        Flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
